// File: rtl/shift_arbiter.sv
// Round-robin arbiter that time-shares one external 16-bit right shifter between NREQ
// requesters and registers each result, tagged with its requester index, into one output stage.
module shift_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [16*NREQ-1:0]  req_data,
    input  logic [4*NREQ-1:0]   req_amt,
    output logic [15:0]         sh_in,
    output logic [3:0]          sh_amt,
    input  logic [15:0]         sh_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         out_data,
    output logic [IDW-1:0]      out_id
);

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     out_data_q, out_data_d;
    logic [IDW-1:0]  out_id_q, out_id_d;

    logic            can_issue;
    logic [NREQ-1:0] ptr_mask;
    logic [NREQ-1:0] hi_req;
    logic            grant_valid;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_oh;

    // A new result may enter whenever the output stage is empty or being drained this cycle.
    assign can_issue = !out_valid_q || out_ready;

    // Requests at or above the pointer win; otherwise the search wraps to the lowest index.
    always_comb begin
        ptr_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            ptr_mask[i] = (IDW'(i) >= rr_ptr_q);
        end
        hi_req = req_valid & ptr_mask;
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (can_issue) begin
            if (|hi_req) begin
                grant_valid = 1'b1;
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (hi_req[i]) begin
                        grant_idx = IDW'(i);
                    end
                end
            end else if (|req_valid) begin
                grant_valid = 1'b1;
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (req_valid[i]) begin
                        grant_idx = IDW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        sh_in    = 16'h0000;
        sh_amt   = 4'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_valid && (grant_idx == IDW'(i))) begin
                grant_oh[i] = 1'b1;
                sh_in       = req_data[16*i +: 16];
                sh_amt      = req_amt[4*i +: 4];
            end
        end
    end

    assign req_ready = grant_oh;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (grant_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = sh_out;
            out_id_d    = grant_idx;
            rr_ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (out_ready) begin
            // Data and id deliberately keep their stale values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_id)));

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomised and directed bench for shift_arbiter: a distance-based round-robin model predicts
// grants, and a scoreboard queue of predicted results is drained by an independent monitor.
module tb_shift_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [16*NREQ-1:0]  req_data = '0;
    logic [4*NREQ-1:0]   req_amt = '0;
    logic [15:0]         sh_in;
    logic [3:0]          sh_amt;
    logic [15:0]         sh_out;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [15:0]         out_data;
    logic [IDW-1:0]      out_id;

    shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .sh_in     (sh_in),
        .sh_amt    (sh_amt),
        .sh_out    (sh_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    // The shared external shifter.
    assign sh_out = sh_in >> sh_amt;

    typedef struct packed {
        logic [15:0]    data;
        logic [IDW-1:0] id;
    } res_t;

    res_t            sb[$];
    int              tests = 0;
    int              fails = 0;
    int              mdl_ptr = 0;
    bit              mdl_valid = 1'b0;
    int              last_grant = -1;
    logic [NREQ-1:0] cur_v = '0;
    logic [15:0]     dv[NREQ];
    logic [3:0]      av[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner is the valid requester at the smallest circular distance from the pointer.
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            int d;
            d = (i - ptr + NREQ) % NREQ;
            if (v[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic step(input logic [NREQ-1:0] v, input logic ordy);
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [15:0]     exp_in;
        logic [3:0]      exp_amt;
        res_t            r;
        @(negedge clk);
        req_valid = v;
        out_ready = ordy;
        for (int i = 0; i < NREQ; i++) begin
            req_data[16*i +: 16] = dv[i];
            req_amt[4*i +: 4]    = av[i];
        end
        #1;
        g = (mdl_valid && !ordy) ? -1 : pick(v, mdl_ptr);
        exp_rdy = '0;
        exp_in  = 16'h0000;
        exp_amt = 4'h0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            exp_in     = dv[g];
            exp_amt    = av[g];
        end
        chk("out_valid", 32'(out_valid), 32'(mdl_valid));
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("sh_in", 32'(sh_in), 32'(exp_in));
        chk("sh_amt", 32'(sh_amt), 32'(exp_amt));
        if (g >= 0) begin
            r.data = dv[g] >> av[g];
            r.id   = IDW'(g);
            sb.push_back(r);
            mdl_valid = 1'b1;
            mdl_ptr   = (g + 1) % NREQ;
        end else if (ordy) begin
            mdl_valid = 1'b0;
        end
        last_grant = g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        chk("pre_reset_valid", 32'(out_valid), 32'(mdl_valid));
        req_valid = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_id", 32'(out_id), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        sb.delete();
        mdl_valid  = 1'b0;
        mdl_ptr    = 0;
        last_grant = -1;
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: out_valid with data %0h id %0h, expected no result",
                         out_data, out_id);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb[0].data));
                chk("out_id", 32'(out_id), 32'(sb[0].id));
                if (out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] nv;
        for (int i = 0; i < NREQ; i++) begin
            dv[i] = 16'($urandom);
            av[i] = 4'($urandom);
        end
        do_reset();

        // Single shift.
        dv[0] = 16'h8000;
        av[0] = 4'd15;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Fairness from reset.
        do_reset();
        repeat (6) step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);

        // Pointer skip and wrap: grant 2, then 3, 1, 3.
        step(4'b0100, 1'b1);
        repeat (3) step(4'b1010, 1'b1);

        // Backpressure with a 16'h0F00 result held.
        dv[2] = 16'hF000;
        av[2] = 4'd4;
        step(4'b0100, 1'b1);
        dv[2] = 16'h1234;
        av[2] = 4'd3;
        repeat (3) step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);

        // Amount sweep.
        dv[1] = 16'hFFFF;
        for (int a = 0; a < 16; a++) begin
            av[1] = 4'(a);
            step(4'b0010, 1'b1);
        end
        step(4'b0000, 1'b1);

        // Reset while a result is held, then restart from requester 0.
        step(4'b1000, 1'b1);
        do_reset();
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);

        // Random traffic; a pending request keeps its operand until granted.
        cur_v = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!cur_v[i] || last_grant == i) begin
                    dv[i] = 16'($urandom);
                    av[i] = 4'($urandom);
                end
            end
            nv = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (cur_v[i] && last_grant != i && ($urandom % 4) != 0) begin
                    nv[i] = 1'b1;
                end
            end
            step(nv, ($urandom % 4) != 0);
            cur_v = nv;
        end

        repeat (3) step(4'b0000, 1'b1);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
